pipe_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/pipe_fwd_sel.sv | 22 ++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the RV32 pipeline control unit: per-stage shadow record,
// forwarding select and halt FSM encodings, plus the producer/source match rule.
package pipe_pkg;

  // Shadow register index width; covers any REG_SIZE up to 8.
  localparam int REG_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic                 useRs1;
    logic                 useRs2;
    logic [REG_IDX_W-1:0] rd;
    logic                 regWrite;
    logic                 mem2reg;
    logic                 finish;
  } stage_info_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  localparam stage_info_t BUBBLE = '0;

  // x0 is never a real producer.
  function automatic logic producerMatch(input stage_info_t p,
                                         input logic [REG_IDX_W-1:0] src,
                                         input logic useSrc);
    return p.valid & p.regWrite & (p.rd != '0) & (p.rd == src) & useSrc;
  endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Operand forwarding select for one execute-stage source: the younger (M)
// producer wins over W, otherwise the register file value is used.
module pipe_fwd_sel
  import pipe_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src,
  input  logic                 useSrc,
  input  stage_info_t          stageM,
  input  stage_info_t          stageW,
  output fwd_sel_t             sel
);

  always_comb begin
    sel = FWD_RF;
    if (producerMatch(stageM, src, useSrc)) begin
      sel = FWD_M;
    end else if (producerMatch(stageW, src, useSrc)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush/forward control for the 5-stage RV32 core, with retired
// counter and finish-drain halt FSM. Forwarding is enabled by PIPE_CTRL_FWD_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_SIZE = 5,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                validD,
  input  logic [REG_SIZE-1:0] rs1D,
  input  logic [REG_SIZE-1:0] rs2D,
  input  logic                useRs1D,
  input  logic                useRs2D,
  input  logic [REG_SIZE-1:0] writeRegD,
  input  logic                regWriteD,
  input  logic                mem2regD,
  input  logic                finishD,
  input  logic                PCSrcM,
  output logic                stallF,
  output logic                stallD,
  output logic                flushD,
  output logic                flushE,
  output logic                flushM,
  output logic [1:0]          fwdAE,
  output logic [1:0]          fwdBE,
  output logic [CNT_W-1:0]    retired,
  output logic                halted
);

  stage_info_t          dInfo;
  stage_info_t          shadowE_p0, shadowM_p1, shadowW_p2;
  logic [REG_IDX_W-1:0] rs1Ext, rs2Ext;
  logic                 matchE1, matchE2, hazard;
  halt_state_t          state, nextState;
  logic                 haltedQ;
  logic [CNT_W-1:0]     retiredCnt;
  logic                 unusedShadow;

  assign rs1Ext = REG_IDX_W'(rs1D);
  assign rs2Ext = REG_IDX_W'(rs2D);

  always_comb begin
    dInfo          = BUBBLE;
    dInfo.valid    = validD;
    dInfo.rs1      = rs1Ext;
    dInfo.rs2      = rs2Ext;
    dInfo.useRs1   = useRs1D;
    dInfo.useRs2   = useRs2D;
    dInfo.rd       = REG_IDX_W'(writeRegD);
    dInfo.regWrite = regWriteD;
    dInfo.mem2reg  = mem2regD;
    dInfo.finish   = finishD;
  end

  assign matchE1 = producerMatch(shadowE_p0, rs1Ext, useRs1D);
  assign matchE2 = producerMatch(shadowE_p0, rs2Ext, useRs2D);

`ifdef PIPE_CTRL_FWD_EN
  fwd_sel_t selA, selB;

  pipe_fwd_sel uFwdA (
    .src    (shadowE_p0.rs1),
    .useSrc (shadowE_p0.useRs1),
    .stageM (shadowM_p1),
    .stageW (shadowW_p2),
    .sel    (selA)
  );

  pipe_fwd_sel uFwdB (
    .src    (shadowE_p0.rs2),
    .useSrc (shadowE_p0.useRs2),
    .stageM (shadowM_p1),
    .stageW (shadowW_p2),
    .sel    (selB)
  );

  assign fwdAE  = selA;
  assign fwdBE  = selB;
  assign hazard = validD & shadowE_p0.mem2reg & (matchE1 | matchE2);
`else
  logic matchM1, matchM2;

  // Without bypass paths the consumer waits until its producer reaches W.
  assign matchM1 = producerMatch(shadowM_p1, rs1Ext, useRs1D);
  assign matchM2 = producerMatch(shadowM_p1, rs2Ext, useRs2D);
  assign fwdAE   = 2'b00;
  assign fwdBE   = 2'b00;
  assign hazard  = validD & (matchE1 | matchE2 | matchM1 | matchM2);
`endif

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    nextState = state;
    case (state)
      RUN: begin
        if (PCSrcM) begin
          flushD = 1'b1;
          flushE = 1'b1;
          flushM = 1'b1;
        end else if (hazard) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end else if (validD && finishD) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        // A redirect here means the finish was on the wrong path.
        if (PCSrcM) begin
          flushD    = 1'b1;
          flushE    = 1'b1;
          flushM    = 1'b1;
          nextState = RUN;
        end else begin
          stallF = 1'b1;
          flushD = 1'b1;
          if (shadowW_p2.valid && shadowW_p2.finish) begin
            nextState = HALTED;
          end
        end
      end
      HALTED: begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      haltedQ          <= 1'b0;
      retiredCnt       <= '0;
      shadowE_p0.valid <= 1'b0;
      shadowM_p1.valid <= 1'b0;
      shadowW_p2.valid <= 1'b0;
    end else begin
      state      <= nextState;
      haltedQ    <= (nextState == HALTED);
      retiredCnt <= retiredCnt + CNT_W'(shadowW_p2.valid);
      // D -> E boundary
      shadowE_p0 <= flushE ? BUBBLE : dInfo;
      // E -> M boundary
      shadowM_p1 <= flushM ? BUBBLE : shadowE_p0;
      // M -> W boundary
      shadowW_p2 <= shadowM_p1;
    end
  end

  assign retired      = retiredCnt;
  assign halted       = haltedQ;
  assign unusedShadow = ^{shadowE_p0, shadowM_p1, shadowW_p2};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl: each row is one cycle of decode
// inputs plus the hand-derived control outputs expected in that cycle.
module tb_pipe_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       m2r;
    logic       fin;
  } ins_t;

  typedef struct {
    logic       rst;
    logic       chk;
    logic       pcs;
    ins_t       ins;
    logic [4:0] sf;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       hlt;
    int         ret;
    string      tag;
  } vec_t;

  // {stallF, stallD, flushD, flushE, flushM}
  localparam logic [4:0] SF_NONE  = 5'b00000;
  localparam logic [4:0] SF_LU    = 5'b11010;
  localparam logic [4:0] SF_RED   = 5'b00111;
  localparam logic [4:0] SF_DRAIN = 5'b10100;
  localparam logic [4:0] SF_HALT  = 5'b11010;
  localparam ins_t       NOP      = '0;

  logic        clk = 1'b0;
  logic        reset, validD, useRs1D, useRs2D, regWriteD, mem2regD, finishD, PCSrcM;
  logic [4:0]  rs1D, rs2D, writeRegD;
  logic        stallF, stallD, flushD, flushE, flushM, halted;
  logic [1:0]  fwdAE, fwdBE;
  logic [31:0] retired;
  logic        stallF4, stallD4, flushD4, flushE4, flushM4, halted4;
  logic [1:0]  fwdAE4, fwdBE4;
  logic [3:0]  retired4;

  vec_t  vq[$];
  string seqName;
  int    cyc;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .validD(validD), .rs1D(rs1D), .rs2D(rs2D),
    .useRs1D(useRs1D), .useRs2D(useRs2D), .writeRegD(writeRegD),
    .regWriteD(regWriteD), .mem2regD(mem2regD), .finishD(finishD), .PCSrcM(PCSrcM),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .fwdAE(fwdAE), .fwdBE(fwdBE), .retired(retired), .halted(halted)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .validD(validD), .rs1D(rs1D), .rs2D(rs2D),
    .useRs1D(useRs1D), .useRs2D(useRs2D), .writeRegD(writeRegD),
    .regWriteD(regWriteD), .mem2regD(mem2regD), .finishD(finishD), .PCSrcM(PCSrcM),
    .stallF(stallF4), .stallD(stallD4), .flushD(flushD4), .flushE(flushE4), .flushM(flushM4),
    .fwdAE(fwdAE4), .fwdBE(fwdBE4), .retired(retired4), .halted(halted4)
  );

  function automatic ins_t alu(input int rd, input int a, input bit ua, input int b, input bit ub);
    ins_t i;
    i = '0; i.v = 1'b1; i.rw = 1'b1;
    i.rd = 5'(rd); i.rs1 = 5'(a); i.u1 = ua; i.rs2 = 5'(b); i.u2 = ub;
    return i;
  endfunction

  function automatic ins_t ld(input int rd, input int a);
    ins_t i;
    i = alu(rd, a, 1'b1, 0, 1'b0);
    i.m2r = 1'b1;
    return i;
  endfunction

  function automatic ins_t br(input int a, input int b);
    ins_t i;
    i = alu(0, a, 1'b1, b, 1'b1);
    i.rw = 1'b0;
    return i;
  endfunction

  function automatic ins_t fin();
    ins_t i;
    i = '0; i.v = 1'b1; i.fin = 1'b1;
    return i;
  endfunction

  task automatic r(input logic pcs, input ins_t i, input logic [4:0] sf,
                   input logic [1:0] fa, input logic [1:0] fb, input logic hlt, input int ret);
    vec_t v;
    v.rst = 1'b0; v.chk = 1'b1; v.pcs = pcs; v.ins = i; v.sf = sf;
    v.fa = fa; v.fb = fb; v.hlt = hlt; v.ret = ret;
    v.tag = $sformatf("%s c%0d", seqName, cyc);
    cyc++;
    vq.push_back(v);
  endtask

  task automatic seq(input string name);
    vec_t v;
    seqName = name;
    cyc = 0;
    v.rst = 1'b1; v.pcs = 1'b0; v.ins = NOP; v.sf = SF_NONE;
    v.fa = 2'b00; v.fb = 2'b00; v.hlt = 1'b0; v.ret = 0;
    v.tag = {name, " reset"};
    v.chk = 1'b0; vq.push_back(v);
    v.chk = 1'b1; vq.push_back(v);
  endtask

  // Forwarding from a load in M would be a control bug.
  always @(negedge clk) begin
    if (reset === 1'b0 && (fwdAE == 2'b01 || fwdBE == 2'b01) && dut.shadowM_p1.mem2reg) begin
      errors++;
      $display("FAIL loadfwd at %0t: fwd=%b/%b with load in M, required no M forward", $time, fwdAE, fwdBE);
    end
  end

  initial begin
    // addi x1,x0,5 ; add x2,x1,x1
    seq("fwdM");
    r(0, alu(1, 0, 1, 0, 0), SF_NONE, 2'b00, 2'b00, 0, 0);
`ifdef PIPE_CTRL_FWD_EN
    r(0, alu(2, 1, 1, 1, 1), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b01, 2'b01, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 2);
`else
    r(0, alu(2, 1, 1, 1, 1), SF_LU, 2'b00, 2'b00, 0, 0);
    r(0, alu(2, 1, 1, 1, 1), SF_LU, 2'b00, 2'b00, 0, 0);
    r(0, alu(2, 1, 1, 1, 1), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 2);
`endif

    // lw x3,0(x0) ; add x4,x3,x0
    seq("loaduse");
    r(0, ld(3, 0), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, alu(4, 3, 1, 0, 1), SF_LU, 2'b00, 2'b00, 0, 0);
`ifdef PIPE_CTRL_FWD_EN
    r(0, alu(4, 3, 1, 0, 1), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b10, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 2);
`else
    r(0, alu(4, 3, 1, 0, 1), SF_LU, 2'b00, 2'b00, 0, 0);
    r(0, alu(4, 3, 1, 0, 1), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 2);
`endif

    // x1 producer in W, x7 producer in M, consumer reads both
    seq("fwdMW");
    r(0, alu(1, 0, 1, 0, 0), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, alu(7, 0, 1, 0, 0), SF_NONE, 2'b00, 2'b00, 0, 0);
`ifdef PIPE_CTRL_FWD_EN
    r(0, alu(2, 7, 1, 1, 1), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b01, 2'b10, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 2);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 3);
`else
    r(0, alu(2, 7, 1, 1, 1), SF_LU, 2'b00, 2'b00, 0, 0);
    r(0, alu(2, 7, 1, 1, 1), SF_LU, 2'b00, 2'b00, 0, 0);
    r(0, alu(2, 7, 1, 1, 1), SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 2);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 2);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 2);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 3);
`endif

    // addi x0,x0,1 ; add x5,x0,x0
    seq("x0dep");
    r(0, alu(0, 0, 1, 0, 0), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, alu(5, 0, 1, 0, 1), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 2);

    // taken beq in M while a load-use pair sits in E/D
    seq("redirect");
    r(0, br(6, 7), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, ld(3, 0), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(1, alu(4, 3, 1, 0, 1), SF_RED, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);

    // seven instructions then finish
    seq("finish");
    for (int k = 0; k < 7; k++) begin
      r(0, alu(10 + k, 0, 1, 0, 0), SF_NONE, 2'b00, 2'b00, 0, (k >= 4) ? k - 3 : 0);
    end
    r(0, fin(), SF_NONE, 2'b00, 2'b00, 0, 4);
    r(0, NOP, SF_DRAIN, 2'b00, 2'b00, 0, 5);
    r(0, NOP, SF_DRAIN, 2'b00, 2'b00, 0, 6);
    r(0, NOP, SF_DRAIN, 2'b00, 2'b00, 0, 7);
    r(0, NOP, SF_HALT, 2'b00, 2'b00, 1, 8);
    r(0, NOP, SF_HALT, 2'b00, 2'b00, 1, 8);
    r(0, NOP, SF_HALT, 2'b00, 2'b00, 1, 8);

    // reset while draining (the next reset pair checks recovery)
    seq("drainrst");
    r(0, fin(), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_DRAIN, 2'b00, 2'b00, 0, 0);

    // finish behind a taken branch is killed
    seq("finkill");
    r(0, br(6, 7), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, fin(), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(1, NOP, SF_RED, 2'b00, 2'b00, 0, 0);
    r(0, alu(9, 0, 1, 0, 0), SF_NONE, 2'b00, 2'b00, 0, 0);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 1);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 2);
    r(0, NOP, SF_NONE, 2'b00, 2'b00, 0, 2);

    // 17 retirements: 32-bit counter reads 17, 4-bit counter wraps to 1
    seq("wrap");
    for (int k = 0; k < 21; k++) begin
      r(0, (k <= 16) ? alu(10, 0, 0, 0, 0) : NOP, SF_NONE, 2'b00, 2'b00, 0,
        (k < 4) ? 0 : ((k - 3 > 17) ? 17 : k - 3));
    end

    for (int n = 0; n < vq.size(); n++) begin
      reset     = vq[n].rst;
      PCSrcM    = vq[n].pcs;
      validD    = vq[n].ins.v;
      rs1D      = vq[n].ins.rs1;
      rs2D      = vq[n].ins.rs2;
      useRs1D   = vq[n].ins.u1;
      useRs2D   = vq[n].ins.u2;
      writeRegD = vq[n].ins.rd;
      regWriteD = vq[n].ins.rw;
      mem2regD  = vq[n].ins.m2r;
      finishD   = vq[n].ins.fin;
      #2;
      if (vq[n].chk) begin
        checks++;
        if ({stallF, stallD, flushD, flushE, flushM} !== vq[n].sf ||
            fwdAE !== vq[n].fa || fwdBE !== vq[n].fb || halted !== vq[n].hlt ||
            retired !== 32'(vq[n].ret) || retired4 !== 4'(vq[n].ret)) begin
          errors++;
          $display("FAIL %s: got sf=%b fwd=%b/%b halted=%b retired=%0d retired4=%0d, want sf=%b fwd=%b/%b halted=%b retired=%0d retired4=%0d",
                   vq[n].tag, {stallF, stallD, flushD, flushE, flushM}, fwdAE, fwdBE, halted,
                   retired, retired4, vq[n].sf, vq[n].fa, vq[n].fb, vq[n].hlt,
                   vq[n].ret, vq[n].ret % 16);
        end
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
